// File: rtl/digit_serial_mag_comp_pkg.sv
// Shared types for the digit-serial magnitude comparator: digit width,
// three-way compare result and its flag decoding.
package cmp_pkg;

    localparam int DIGIT_W = 2;

    typedef enum logic [1:0] {
        CMP_EQ = 2'b00,
        CMP_LT = 2'b01,
        CMP_GT = 2'b10
    } cmp_res_t;

    // Returns {eq, lt, gt}; always one-hot.
    function automatic logic [2:0] to_flags(input cmp_res_t res);
        logic [2:0] flags;
        case (res)
            CMP_LT:  flags = 3'b010;
            CMP_GT:  flags = 3'b001;
            default: flags = 3'b100;
        endcase
        return flags;
    endfunction

endpackage

// File: rtl/digit_serial_mag_comp_digit_cmp.sv
// Combinational compare of one digit pair, producing a three-way result.
module digit_cmp
    import cmp_pkg::*;
#(
    parameter int DIGIT_W = cmp_pkg::DIGIT_W
) (
    input  logic [DIGIT_W-1:0] i_a,
    input  logic [DIGIT_W-1:0] i_b,
    output cmp_res_t           o_res
);

    always_comb begin
        o_res = CMP_EQ;
        if (i_a > i_b)
            o_res = CMP_GT;
        else if (i_a < i_b)
            o_res = CMP_LT;
    end

endmodule

// File: rtl/digit_serial_mag_comp.sv
// LSB-first digit-serial unsigned magnitude comparator with valid/ready
// handshakes on the digit stream and on the held result.
module digit_serial_mag_comp
    import cmp_pkg::*;
#(
    parameter  int DIGIT_W    = cmp_pkg::DIGIT_W,
    parameter  int MAX_DIGITS = 16,
    localparam int CNT_W      = $clog2(MAX_DIGITS + 1)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [DIGIT_W-1:0] a_digit,
    input  logic [DIGIT_W-1:0] b_digit,
    input  logic               in_last,
    output logic               out_valid,
    input  logic               out_ready,
    output logic               A_eq_B,
    output logic               A_lt_B,
    output logic               A_gt_B,
    output logic               len_err,
    output logic [CNT_W-1:0]   digit_cnt
);

    typedef enum logic {
        ST_ACCUM = 1'b0,
        ST_HOLD  = 1'b1
    } state_t;

    state_t           r_state;
    cmp_res_t         r_verdict;
    logic [CNT_W-1:0] r_cnt;
    logic             r_out_valid;
    logic [2:0]       r_flags;
    logic             r_len_err;
    logic [CNT_W-1:0] r_digit_cnt;

    cmp_res_t         w_beat_res;
    cmp_res_t         w_next_verdict;
    logic [CNT_W-1:0] w_cnt_next;
    logic             w_term;

    digit_cmp #(
        .DIGIT_W(DIGIT_W)
    ) u_digit_cmp (
        .i_a   (a_digit),
        .i_b   (b_digit),
        .o_res (w_beat_res)
    );

    // LSB-first: any difference at this digit outranks everything seen so far.
    always_comb begin
        w_next_verdict = r_verdict;
        if (w_beat_res != CMP_EQ)
            w_next_verdict = w_beat_res;
        w_cnt_next = r_cnt;
        if (r_cnt != CNT_W'(MAX_DIGITS))
            w_cnt_next = r_cnt + 1'b1;
        w_term = in_last || (w_cnt_next == CNT_W'(MAX_DIGITS));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_ACCUM;
            r_verdict   <= CMP_EQ;
            r_cnt       <= '0;
            r_out_valid <= 1'b0;
            r_flags     <= 3'b100;
            r_len_err   <= 1'b0;
            r_digit_cnt <= '0;
        end else begin
            case (r_state)
                ST_ACCUM: begin
                    if (in_valid) begin
                        r_cnt     <= w_cnt_next;
                        r_verdict <= w_next_verdict;
                        if (w_term) begin
                            r_state     <= ST_HOLD;
                            r_out_valid <= 1'b1;
                            r_flags     <= to_flags(w_next_verdict);
                            r_len_err   <= !in_last;
                            r_digit_cnt <= w_cnt_next;
                        end
                    end
                end
                ST_HOLD: begin
                    // Flags and digit_cnt are left as-is; out_valid disqualifies them.
                    if (out_ready) begin
                        r_state     <= ST_ACCUM;
                        r_out_valid <= 1'b0;
                        r_cnt       <= '0;
                        r_verdict   <= CMP_EQ;
                        r_len_err   <= 1'b0;
                    end
                end
                default: r_state <= ST_ACCUM;
            endcase
        end
    end

    assign in_ready  = (r_state == ST_ACCUM);
    assign out_valid = r_out_valid;
    assign A_eq_B    = r_flags[2];
    assign A_lt_B    = r_flags[1];
    assign A_gt_B    = r_flags[0];
    assign len_err   = r_len_err;
    assign digit_cnt = r_digit_cnt;

endmodule

// File: tb/tb_digit_serial_mag_comp.sv
// Directed self-checking bench for digit_serial_mag_comp.
module tb_digit_serial_mag_comp;

    logic       clk;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [1:0] a_digit;
    logic [1:0] b_digit;
    logic       in_last;
    logic       out_valid;
    logic       out_ready;
    logic       A_eq_B;
    logic       A_lt_B;
    logic       A_gt_B;
    logic       len_err;
    logic [4:0] digit_cnt;

    int unsigned n_pass  = 0;
    int unsigned n_total = 0;

    digit_serial_mag_comp #(
        .MAX_DIGITS(16)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a_digit   (a_digit),
        .b_digit   (b_digit),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .A_eq_B    (A_eq_B),
        .A_lt_B    (A_lt_B),
        .A_gt_B    (A_gt_B),
        .len_err   (len_err),
        .digit_cnt (digit_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    endtask

    // Result checks: out_valid, {eq,lt,gt}, len_err, digit_cnt
    task automatic chk_res(input string tag, input logic [2:0] flags,
                           input logic lerr, input logic [4:0] cnt);
        chk({tag, ".valid"}, 32'(out_valid), 32'd1);
        chk({tag, ".flags"}, 32'({A_eq_B, A_lt_B, A_gt_B}), 32'(flags));
        chk({tag, ".len_err"}, 32'(len_err), 32'(lerr));
        chk({tag, ".cnt"}, 32'(digit_cnt), 32'(cnt));
    endtask

    // One accepted beat; sampled 1 time unit after the accepting edge
    task automatic beat(input logic [1:0] a, input logic [1:0] b, input logic last);
        a_digit  = a;
        b_digit  = b;
        in_last  = last;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic consume(input string tag);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        chk({tag, ".released"}, 32'(out_valid), 32'd0);
        chk({tag, ".in_ready"}, 32'(in_ready), 32'd1);
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        a_digit   = '0;
        b_digit   = '0;
        in_last   = 1'b0;
        out_ready = 1'b0;
        #12;
        chk("rst.out_valid", 32'(out_valid), 32'd0);
        chk("rst.flags", 32'({A_eq_B, A_lt_B, A_gt_B}), 32'b100);
        chk("rst.len_err", 32'(len_err), 32'd0);
        chk("rst.cnt", 32'(digit_cnt), 32'd0);
        rst_n = 1'b1;
        #1;
        chk("rst.in_ready", 32'(in_ready), 32'd1);

        // A=B=0x1B, 4 digits
        beat(2'd3, 2'd3, 1'b0);
        beat(2'd2, 2'd2, 1'b0);
        beat(2'd1, 2'd1, 1'b0);
        chk("eq.pending", 32'(out_valid), 32'd0);
        beat(2'd0, 2'd0, 1'b1);
        chk_res("eq", 3'b100, 1'b0, 5'd4);
        chk("eq.in_ready", 32'(in_ready), 32'd0);
        consume("eq");

        // A=0111 < B=1000: MSB difference overrides LSB
        beat(2'd3, 2'd0, 1'b0);
        beat(2'd1, 2'd2, 1'b1);
        chk_res("lt", 3'b010, 1'b0, 5'd2);
        consume("lt");

        // A=1100 > B=0111, then stall with junk beats offered
        beat(2'd0, 2'd3, 1'b0);
        beat(2'd3, 2'd1, 1'b1);
        chk_res("gt", 3'b001, 1'b0, 5'd2);
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1;
            a_digit  = 2'(i);
            b_digit  = 2'(3 - i);
            in_last  = i[0];
            @(posedge clk);
            #1;
            chk("hold.flags", 32'({out_valid, A_eq_B, A_lt_B, A_gt_B}), 32'b1001);
            chk("hold.cnt", 32'(digit_cnt), 32'd2);
            chk("hold.in_ready", 32'(in_ready), 32'd0);
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        consume("gt");

        // 16 digits, no in_last: forced termination with len_err
        beat(2'd2, 2'd1, 1'b0);
        for (int i = 1; i < 15; i++) beat(2'd1, 2'd1, 1'b0);
        chk("force.pending", 32'(out_valid), 32'd0);
        beat(2'd1, 2'd1, 1'b0);
        chk_res("force", 3'b001, 1'b1, 5'd16);
        consume("force");
        beat(2'd2, 2'd2, 1'b0);
        beat(2'd1, 2'd1, 1'b1);
        chk_res("fresh", 3'b100, 1'b0, 5'd2);
        consume("fresh");

        // Back-to-back with in_valid and out_ready held high
        out_ready = 1'b1;
        in_valid  = 1'b1;
        a_digit   = 2'd2;
        b_digit   = 2'd1;
        in_last   = 1'b1;
        @(posedge clk);
        #1;
        chk_res("b2b1", 3'b001, 1'b0, 5'd1);
        chk("b2b1.in_ready", 32'(in_ready), 32'd0);
        a_digit = 2'd1;
        b_digit = 2'd1;
        @(posedge clk);
        #1;
        chk("bubble.out_valid", 32'(out_valid), 32'd0);
        chk("bubble.in_ready", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;
        chk_res("b2b2", 3'b100, 1'b0, 5'd1);
        in_valid = 1'b0;
        in_last  = 1'b0;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        chk("b2b.done", 32'(out_valid), 32'd0);

        // Asynchronous reset mid-operand
        beat(2'd3, 2'd0, 1'b0);
        beat(2'd3, 2'd0, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst.out_valid", 32'(out_valid), 32'd0);
        chk("arst.flags", 32'({A_eq_B, A_lt_B, A_gt_B}), 32'b100);
        chk("arst.cnt", 32'(digit_cnt), 32'd0);
        #2;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        beat(2'd0, 2'd3, 1'b1);
        chk_res("arst.lt", 3'b010, 1'b0, 5'd1);
        consume("arst");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/digit_serial_mag_comp.md
Name: digit_serial_mag_comp

Overview:
- Sequential magnitude comparator for two unsigned operands of arbitrary length.
- Operands arrive as 2-bit digits, least-significant digit first; the block keeps a running eq/lt/gt verdict and emits one result per operand pair.
- It complements the combinational 2-bit comparator: it is the serial, LSB-first form used when operands stream from narrow datapaths.
- Input and result use valid/ready handshakes.

Parameters:
- DIGIT_W, 2, bits per digit; fixed at 2, kept as a parameter for the package constant.
- MAX_DIGITS, 16, maximum digits per operand; the MAX_DIGITS-th digit is forced to be the last.
- CNT_W, $clog2(MAX_DIGITS+1), digit counter width (derived; not overridden).

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  digit pair present.
- in_ready  output  1  block accepts a digit this cycle.
- a_digit  input  DIGIT_W  digit of operand A, LSB-first order.
- b_digit  input  DIGIT_W  digit of operand B, same position as a_digit.
- in_last  input  1  this digit is the most-significant digit of the operand.
- out_valid  output  1  result held.
- out_ready  input  1  consumer takes the result.
- A_eq_B  output  1  A == B.
- A_lt_B  output  1  A < B.
- A_gt_B  output  1  A > B.
- len_err  output  1  operand hit MAX_DIGITS without in_last; qualified by out_valid.
- digit_cnt  output  CNT_W  digits consumed for the held result; qualified by out_valid.

Behaviour:
- States: ACCUM and HOLD. Reset state is ACCUM, running verdict is EQ, counter is 0.
- Reset values: out_valid=0, A_eq_B=1, A_lt_B=0, A_gt_B=0, len_err=0, digit_cnt=0. in_ready=1 once out of reset.
- in_ready = (state==ACCUM). There is no combinational path from out_ready to in_ready; one bubble cycle follows each result.
- Beat accepted when in_valid && in_ready.
- Per beat, the verdict updates as follows:
  - a_digit > b_digit: verdict becomes GT.
  - a_digit < b_digit: verdict becomes LT.
  - digits equal: verdict is unchanged.
  - Because digits arrive LSB-first, a higher-significance difference always overrides earlier ones.
- Verdict for the first beat of an operand starts from EQ, never from the previous operand's result.
- Counter increments per accepted beat and saturates at MAX_DIGITS.
- Accepted beat with in_last=1, or the beat that makes the counter equal MAX_DIGITS:
  - Next cycle: state=HOLD, out_valid=1.
  - Result flags are registered, exactly one-hot, and stable while out_valid=1.
  - digit_cnt = number of digits including the last one.
  - len_err=1 only when the termination was forced and in_last was 0.
- Latency: result is visible 1 cycle after the last digit is accepted.
- In HOLD, out_valid && out_ready returns the block to ACCUM next cycle. At the same time: out_valid=0, counter=0, verdict=EQ, len_err=0. The output flags keep their last value but are not qualified.
- In HOLD, in_valid is ignored and digit inputs may change freely.
- After a forced termination, following digits start a new operand pair. No resynchronisation is attempted.
- Single-digit operand (first beat has in_last=1) is legal; digit_cnt=1.
- in_valid=0 in ACCUM holds all state; gaps between digits are legal.
- rst_n low at any time (mid-operand or in HOLD) clears to reset values immediately. Partial operands are discarded.

Decomposition:
- Package cmp_pkg holds:
  - DIGIT_W constant.
  - Enum cmp_res_t {CMP_EQ, CMP_LT, CMP_GT} (2-bit encoding).
  - Function to_flags(cmp_res_t) returning {eq, lt, gt}.
- Sub-module digit_cmp: combinational DIGIT_W compare of a_digit/b_digit returning cmp_res_t. It holds no state.
- Top module holds the FSM, counter, verdict register and output registers.

Test Plan:
- A=0x1B, B=0x1B over 4 digits (LSB-first 3/3, 2/2, 1/1, 0/0, last on 4th) -> one cycle after last: out_valid=1, A_eq_B=1, digit_cnt=4, len_err=0.
- A=0b0111, B=0b1000 (digits 3/0, 1/2, last) -> LSB says GT, MSB overrides -> A_lt_B=1, digit_cnt=2.
- A=0b1100, B=0b0111 (digits 0/3, 3/1, last) -> A_gt_B=1. Hold out_ready=0 for 5 cycles -> flags stable, in_ready=0, in_valid beats ignored.
- 16 equal digits except digit 0 (a=2, b=1), in_last never asserted -> forced end after 16th beat, A_gt_B=1, len_err=1, digit_cnt=16. The next beat starts a fresh operand with verdict EQ.
- Back-to-back operands with in_valid held high and out_ready=1 -> one bubble per result. The second result is unaffected by the first (first GT, second single digit 1/1 -> A_eq_B=1).
- Assert rst_n=0 asynchronously after 2 of 4 digits, release, send single digit 0/3 last -> A_lt_B=1, digit_cnt=1.
